mau_cmd_issuer: RTL

- Upstream feeder for the MAU core: buffers host command bytes and issues them on the MAU's 8-bit host_instruction/data_in buses, paced by busy_flag.
- Buffering is in an internal byte FIFO. A command is issued only when it is fully resident, so the MAU never sees a gap in a data burst.
- Sits between the host-side byte source and the MAU instance.
- Flags framing and timeout errors.

---
 rtl/mau_pkg.sv | 17 +
 rtl/mau_byte_fifo.sv | 42 ++++
 rtl/mau_cmd_issuer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the MAU command issuer.
package mau_pkg;
  localparam logic [7:0] MAU_NOP = 8'h00;
  typedef struct packed {
    logic [7:0] data;
    logic       is_op;
    logic       last;
  } fifo_entry_t;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_STREAM    = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_FLUSH     = 3'd5
  } issuer_state_t;
endpackage

// File: rtl/mau_byte_fifo.sv
// mau_byte_fifo: synchronous FIFO of command byte entries with count and full/empty flags.
module mau_byte_fifo
  import mau_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fifo_entry_t              wdata_i,
  output fifo_entry_t              head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  fifo_entry_t mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(do_push);
      rptr_q  <= rptr_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mau_cmd_issuer.sv
// mau_cmd_issuer: buffers host command bytes and issues whole commands to the MAU, paced by busy_flag.
module mau_cmd_issuer
  import mau_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       in_is_op,
  input  logic       in_last,
  output logic [7:0] host_instruction,
  output logic [7:0] data_in,
  input  logic       busy_flag,
  output logic       issuing,
  output logic       err_frame,
  output logic       err_timeout
);
  localparam int AW = $clog2(DEPTH);
  issuer_state_t state_q, state_d;
  logic [7:0] host_q, host_d, data_q, data_d;
  logic issuing_q, issuing_d, err_frame_q, err_frame_d, err_timeout_q, err_timeout_d;
  logic op_last_q, op_last_d, busy_seen_q, busy_seen_d, rst_q;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [AW:0] pending_q, count;
  logic push, pop, full, empty;
  fifo_entry_t head;
  assign in_ready = !full && !rst_q && state_q != S_FLUSH;
  assign push = in_valid && in_ready;
  mau_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ('{data: in_byte, is_op: in_is_op, last: in_last}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_comb begin
    state_d       = state_q;
    host_d        = MAU_NOP;
    data_d        = 8'h00;
    pop           = 1'b0;
    issuing_d     = issuing_q;
    err_frame_d   = err_frame_q;
    err_timeout_d = err_timeout_q;
    op_last_d     = op_last_q;
    busy_seen_d   = busy_seen_q | busy_flag;
    tcnt_d        = tcnt_q < CW'(TIMEOUT-1) ? tcnt_q + CW'(1) : tcnt_q;
    case (state_q)
      S_IDLE:
        if (count == (AW+1)'(DEPTH) && pending_q == '0) begin
          err_frame_d = 1'b1;
          state_d     = S_FLUSH;
        end else if (pending_q != '0 && !busy_flag) begin
          pop = 1'b1;
          if (!head.is_op || head.data == MAU_NOP) err_frame_d = 1'b1;
          else begin
            state_d     = S_ISSUE;
            host_d      = head.data;
            issuing_d   = 1'b1;
            op_last_d   = head.last;
            busy_seen_d = 1'b0;
            tcnt_d      = '0;
          end
        end
      S_ISSUE, S_STREAM:
        if (state_q == S_ISSUE && op_last_q) state_d = S_WAIT_BUSY;
        else if (!empty) begin
          pop         = 1'b1;
          data_d      = head.is_op ? 8'h00 : head.data;
          err_frame_d = err_frame_q | head.is_op;
          state_d     = (head.is_op || head.last) ? S_WAIT_BUSY : S_STREAM;
        end else state_d = S_STREAM;
      S_WAIT_BUSY:
        if (busy_seen_q || busy_flag) state_d = S_WAIT_DONE;
        else if (tcnt_q >= CW'(TIMEOUT-1)) begin
          err_timeout_d = 1'b1;
          issuing_d     = 1'b0;
          state_d       = S_IDLE;
        end
      S_WAIT_DONE:
        if (!busy_flag) begin
          issuing_d = 1'b0;
          state_d   = S_IDLE;
        end
      S_FLUSH:
        if (empty) state_d = S_IDLE;
        else pop = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q       <= S_IDLE;
      host_q        <= MAU_NOP;
      data_q        <= 8'h00;
      issuing_q     <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      op_last_q     <= 1'b0;
      busy_seen_q   <= 1'b0;
      tcnt_q        <= '0;
      pending_q     <= '0;
    end else begin
      state_q       <= state_d;
      host_q        <= host_d;
      data_q        <= data_d;
      issuing_q     <= issuing_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
      op_last_q     <= op_last_d;
      busy_seen_q   <= busy_seen_d;
      tcnt_q        <= tcnt_d;
      pending_q     <= pending_q + (AW+1)'(push && in_last) - (AW+1)'(pop && !empty && head.last);
    end
  end
  assign host_instruction = host_q;
  assign data_in          = data_q;
  assign issuing          = issuing_q;
  assign err_frame        = err_frame_q;
  assign err_timeout      = err_timeout_q;
endmodule
